// File: rtl/voice_pkg.sv
// Shared definitions for the voice-change frame sequencer: state encoding,
// stage indices and helpers that map a stage state to its start/done bit.
package voice_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SHIFT = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int STG_PRE     = 0;
  localparam int STG_SHIFT   = 1;
  localparam int STG_POST    = 2;
  localparam int NUM_STG     = 3;
  localparam int TIMEOUT_DEF = 1024;

  // One-hot start/done bit owned by a stage state; zero for non-stage states.
  function automatic logic [NUM_STG-1:0] stage_bit(input state_t s);
    logic [NUM_STG-1:0] b;
    b = '0;
    case (s)
      S_PRE:   b[STG_PRE]   = 1'b1;
      S_SHIFT: b[STG_SHIFT] = 1'b1;
      S_POST:  b[STG_POST]  = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      S_PRE:   return S_SHIFT;
      S_SHIFT: return S_POST;
      default: return S_DONE;
    endcase
  endfunction

endpackage

// File: rtl/dffre.sv
// Generic register with async active-high reset and load enable.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/voice_seq_ctrl.sv
// Per-frame sequencer: latches mode switches on the frame strobe, runs
// pre-filter / pitch-shift / post-filter in turn and updates bypass muxes.
module voice_seq_ctrl
  import voice_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_strobe,
  input  logic             change_en,
  input  logic             rising_tone,
  input  logic             clr_stats,
  output logic [2:0]       stage_start,
  input  logic [2:0]       stage_done,
  output logic             pre_sel,
  output logic             out_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  // sw_* bit 0 = change_en, bit 1 = rising_tone
  logic [1:0] sw_meta, sw_sync;

  dffre #(.W(2)) u_sync0 (
    .clk(clk), .reset(reset), .en(1'b1),
    .d({rising_tone, change_en}), .q(sw_meta)
  );
  dffre #(.W(2)) u_sync1 (
    .clk(clk), .reset(reset), .en(1'b1),
    .d(sw_meta), .q(sw_sync)
  );

  state_t            state;
  logic              m_en, m_rt, err;
  logic [WC_W-1:0]   wcnt;
  logic              stage_hit, wait_exp, ovr_inc;

  // wcnt is zero only on the start cycle, so a done there is ignored.
  assign stage_hit = (|(stage_done & stage_bit(state))) && (wcnt != '0);
  assign wait_exp  = (stage_bit(state) != 3'b000) && !stage_hit &&
                     (wcnt == WC_W'(TIMEOUT - 1));
  assign ovr_inc   = frame_strobe && (state != S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      m_en        <= 1'b0;
      m_rt        <= 1'b0;
      err         <= 1'b0;
      wcnt        <= '0;
      stage_start <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      pre_sel     <= 1'b0;
      out_sel     <= 1'b0;
    end else begin
      stage_start <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_strobe) begin
            m_en <= sw_sync[0];
            m_rt <= sw_sync[1];
            err  <= 1'b0;
            wcnt <= '0;
            if (!sw_sync[0]) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
            end else if (sw_sync[1]) begin
              state       <= S_PRE;
              stage_start <= stage_bit(S_PRE);
            end else begin
              state       <= S_SHIFT;
              stage_start <= stage_bit(S_SHIFT);
            end
          end
        end
        S_PRE, S_SHIFT, S_POST: begin
          if (stage_hit) begin
            state       <= next_state(state);
            stage_start <= stage_bit(next_state(state));
            frame_done  <= (state == S_POST);
            wcnt        <= '0;
          end else if (wait_exp) begin
            state      <= S_DONE;
            err        <= 1'b1;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            wcnt       <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE: begin
          // Aborted frames fall back to raw passthrough.
          state   <= S_IDLE;
          pre_sel <= !err && m_rt;
          out_sel <= !err && m_en;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_ovr_cnt (
    .clk(clk), .reset(reset), .inc(ovr_inc), .clr(clr_stats), .cnt(overrun_cnt)
  );
  sat_counter #(.W(CNT_W)) u_to_cnt (
    .clk(clk), .reset(reset), .inc(wait_exp), .clr(clr_stats), .cnt(timeout_cnt)
  );

endmodule

// File: tb/tb_voice_seq_ctrl.sv
// Bench for voice_seq_ctrl: directed vector table, reset corner case and
// randomized frames checked against a frame-level timing model.
module tb_voice_seq_ctrl;

  localparam int TO   = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_strobe = 1'b0;
  logic          change_en = 1'b0;
  logic          rising_tone = 1'b0;
  logic          clr_stats = 1'b0;
  logic [2:0]    stage_start;
  logic [2:0]    stage_done = '0;
  logic          pre_sel, out_sel, busy, frame_done, frame_err;
  logic [CW-1:0] overrun_cnt, timeout_cnt;

  int total = 0;
  int bad   = 0;
  int dly[3] = '{-1, -1, -1};
  int cd[3]  = '{0, 0, 0};
  bit armed[3] = '{0, 0, 0};

  // d: cycles from start to done (0 = in the start cycle, -1 = never)
  typedef struct {
    bit          en, rt;
    int          d0, d1, d2;
    logic [63:0] ovr, clr;
    int          s0, s1, s2, len;
    bit          err, pre, out;
    int          ovc, toc;
  } vec_t;

  vec_t tab[10];

  always #5 clk = ~clk;

  voice_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .frame_strobe(frame_strobe),
    .change_en(change_en), .rising_tone(rising_tone), .clr_stats(clr_stats),
    .stage_start(stage_start), .stage_done(stage_done),
    .pre_sel(pre_sel), .out_sel(out_sel), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );

  // Fake processing stages: reply dly[i] cycles after their start pulse.
  always @(negedge clk) begin
    logic [2:0] dv;
    dv = '0;
    for (int i = 0; i < 3; i++) begin
      if (reset) armed[i] = 1'b0;
      else begin
        if (stage_start[i] && dly[i] >= 0) begin armed[i] = 1'b1; cd[i] = dly[i]; end
        else if (armed[i]) cd[i] = cd[i] - 1;
        if (armed[i] && cd[i] == 0) begin dv[i] = 1'b1; armed[i] = 1'b0; end
      end
    end
    stage_done = dv;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame timing from the rules: each stage lasts d+1 cycles if done comes
  // on a legal cycle, otherwise TIMEOUT cycles and the frame aborts.
  function automatic void model_path(inout vec_t v);
    int d[3];
    int off;
    d = '{v.d0, v.d1, v.d2};
    off = 1; v.s0 = 0; v.s1 = 0; v.s2 = 0; v.err = 0;
    if (v.en) begin
      for (int st = (v.rt ? 0 : 1); st < 3; st++) begin
        if (st == 0) v.s0 = off; else if (st == 1) v.s1 = off; else v.s2 = off;
        if (d[st] >= 1 && d[st] <= TO - 1) off += d[st] + 1;
        else begin off += TO; v.err = 1; break; end
      end
    end
    v.len = off;
    v.pre = v.err ? 1'b0 : v.rt;
    v.out = v.err ? 1'b0 : v.en;
  endfunction

  function automatic void model_cnt(inout vec_t v, inout int oc, inout int tc);
    for (int k = 1; k <= v.len; k++) begin
      if (v.clr[k]) begin oc = 0; tc = 0; end
      else begin
        if (v.ovr[k] && oc < CMAX) oc++;
        if (v.err && k == v.len - 1 && tc < CMAX) tc++;
      end
    end
    v.ovc = oc; v.toc = tc;
  endfunction

  task automatic apply(input vec_t v, input int id, input bit clr_first);
    int nfd, fdk, fe, sbad, bbad;
    logic [2:0] se;
    if (clr_first) begin clr_stats = 1'b1; tick; clr_stats = 1'b0; end
    change_en = v.en; rising_tone = v.rt;
    dly = '{v.d0, v.d1, v.d2};
    tick; tick; tick;
    frame_strobe = 1'b1;
    nfd = 0; fdk = -1; fe = -1; sbad = 0; bbad = 0;
    for (int k = 1; k <= v.len + 1; k++) begin
      tick;
      frame_strobe = (k <= v.len) ? v.ovr[k] : 1'b0;
      clr_stats    = (k <= v.len) ? v.clr[k] : 1'b0;
      se = {3'(k == v.s2 && v.s2 != 0) << 2} | {3'(k == v.s1 && v.s1 != 0) << 1}
         | 3'(k == v.s0 && v.s0 != 0);
      if (stage_start !== se) sbad++;
      if (busy !== (k <= v.len)) bbad++;
      if (frame_done) begin nfd++; fdk = k; fe = int'(frame_err); end
      if (k == v.len + 1) begin
        chk($sformatf("v%0d pre_sel", id), pre_sel, v.pre);
        chk($sformatf("v%0d out_sel", id), out_sel, v.out);
        chk($sformatf("v%0d overrun_cnt", id), overrun_cnt, v.ovc);
        chk($sformatf("v%0d timeout_cnt", id), timeout_cnt, v.toc);
      end
    end
    frame_strobe = 1'b0; clr_stats = 1'b0;
    chk($sformatf("v%0d start_bad_cycles", id), sbad, 0);
    chk($sformatf("v%0d busy_bad_cycles", id), bbad, 0);
    chk($sformatf("v%0d frame_done_count", id), nfd, 1);
    chk($sformatf("v%0d frame_done_cycle", id), fdk, v.len);
    chk($sformatf("v%0d frame_err", id), fe, int'(v.err));
  endtask

  initial begin
    int oc, tc, nfd, nb, r;
    int d[3];
    vec_t v;
    //        en rt  d0  d1  d2  ovr mask                         clr mask   s0 s1 s2 len err pre out ovc toc
    tab[0] = '{1, 1,  1,  1,  1, 64'd0,                           64'd0,     1, 3, 5,  7, 0, 1, 1, 0, 0};
    tab[1] = '{1, 0, -1,  1,  1, 64'd0,                           64'd0,     0, 1, 3,  5, 0, 0, 1, 0, 0};
    tab[2] = '{0, 1,  1,  1,  1, 64'd0,                           64'd0,     0, 0, 0,  1, 0, 1, 0, 0, 0};
    tab[3] = '{1, 0, -1,  0,  1, 64'd0,                           64'd0,     0, 1, 0, 17, 1, 0, 0, 0, 1};
    tab[4] = '{1, 1,  1,  1,  1, (64'd1<<3)|(64'd1<<7),           64'd0,     1, 3, 5,  7, 0, 1, 1, 2, 0};
    tab[5] = '{1, 1,  1,  1, -1, 64'd0,                           64'd0,     1, 3, 5, 21, 1, 0, 0, 0, 1};
    tab[6] = '{1, 0, -1, 10, 10, (64'd1<<2)|(64'd1<<4)|(64'd1<<6)|(64'd1<<8)|(64'd1<<10),
                                                                  64'd0,     0, 1,12, 23, 0, 0, 1, 3, 0};
    tab[7] = '{1, 0, -1,  5,  5, (64'd1<<2)|(64'd1<<3)|(64'd1<<4)|(64'd1<<6),
                                                                  64'd1<<6,  0, 1, 7, 13, 0, 0, 1, 0, 0};
    tab[8] = '{1, 1, -1,  1,  1, 64'd0,                           64'd1<<16, 1, 0, 0, 17, 1, 0, 0, 0, 0};
    tab[9] = '{1, 0, -1, 15,  1, 64'd0,                           64'd0,     0, 1,17, 19, 0, 0, 1, 0, 0};

    // Reset state
    repeat (3) tick;
    chk("rst stage_start", stage_start, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst pre_sel", pre_sel, 0);
    chk("rst out_sel", out_sel, 0);
    chk("rst overrun_cnt", overrun_cnt, 0);
    chk("rst timeout_cnt", timeout_cnt, 0);
    reset = 1'b0;
    tick;

    apply(tab[0], 100, 1'b1);

    // Reset in the middle of SHIFT abandons the frame.
    change_en = 1'b1; rising_tone = 1'b1; dly = '{1, -1, -1};
    tick; tick; tick;
    frame_strobe = 1'b1;
    tick; frame_strobe = 1'b0;
    tick; tick; tick;
    chk("mid busy before reset", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid rst stage_start", stage_start, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst frame_done", frame_done, 0);
    chk("mid rst frame_err", frame_err, 0);
    chk("mid rst pre_sel", pre_sel, 0);
    chk("mid rst out_sel", out_sel, 0);
    tick; tick;
    reset = 1'b0;
    nfd = 0; nb = 0;
    repeat (20) begin tick; nfd += int'(frame_done); nb += int'(busy); end
    chk("post rst frame_done count", nfd, 0);
    chk("post rst busy cycles", nb, 0);

    for (int i = 0; i < 10; i++) apply(tab[i], i, 1'b1);

    // Randomized frames with running counter model.
    oc = 0; tc = 0;
    for (int n = 0; n < 40; n++) begin
      v.en = 1'($urandom_range(0, 3) != 0);
      v.rt = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) begin
        r = $urandom_range(0, 19);
        d[s] = (r == 0) ? 0 : (r == 1) ? -1 : (r == 2) ? TO - 1 : int'($urandom_range(1, 6));
      end
      v.d0 = d[0]; v.d1 = d[1]; v.d2 = d[2];
      v.ovr = '0; v.clr = '0;
      model_path(v);
      for (int k = 1; k <= v.len; k++) begin
        v.ovr[k] = ($urandom_range(0, 7) == 0);
        v.clr[k] = ($urandom_range(0, 29) == 0);
      end
      if (n == 0) begin oc = 0; tc = 0; end
      model_cnt(v, oc, tc);
      apply(v, 200 + n, n == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_seq_ctrl.md
# voice_seq_ctrl

Per-frame sequencer for the voice-change datapath. On each audio frame strobe it latches the user mode switches, then issues start pulses in order to the pre-filter, pitch-shift and post-filter stages, waiting for each stage's done. It drives the frame-synchronous bypass selects and keeps saturating overrun and timeout statistics. It sits between the codec frame-edge detector and the three processing stages, replacing free-running stage enables.

## Interface
- TIMEOUT, 1024: maximum cycles to wait for a stage done before aborting the frame.
- CNT_W, 8: width of the statistics counters.
- clk  in  1  system clock (sys_clk domain).
- reset  in  1  asynchronous, active-high.
- frame_strobe  in  1  one-cycle pulse per audio frame; the rising edge of NewFrame, already in the clk domain.
- change_en  in  1  raw switch: 1 = process, 0 = bypass. Asynchronous.
- rising_tone  in  1  raw switch: 1 = pre-filter before the shift. Asynchronous.
- clr_stats  in  1  synchronous clear of both counters.
- stage_start  out  3  one-cycle start pulses: [0] pre, [1] shift, [2] post.
- stage_done  in  3  stage completion pulses, same bit order.
- pre_sel  out  1  shift-input mux: 1 = pre-filter output, 0 = raw sample.
- out_sel  out  1  playback mux: 1 = processed, 0 = raw.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- frame_err  out  1  qualifies frame_done: 1 = frame aborted by timeout.
- overrun_cnt  out  CNT_W  count of dropped strobes, saturating.
- timeout_cnt  out  CNT_W  count of stage timeouts, saturating.

## Operation
- change_en and rising_tone each pass through a 2-flop synchronizer. Only the synchronized values are used.
- The FSM has five states: IDLE, PRE, SHIFT, POST, DONE.
- In IDLE, frame_strobe latches m_en and m_rt from the synchronized switches, then:
  - m_en=0: go to DONE.
  - m_en=1 and m_rt=1: go to PRE.
  - m_en=1 and m_rt=0: go to SHIFT.
- On entry to each stage state, the matching stage_start bit is high for exactly the first cycle of the state.
- stage_done is sampled only from the second cycle of the state onward. A done on the start cycle is ignored. Done bits of other stages are always ignored.
- Stage transitions on done: PRE to SHIFT, SHIFT to POST, POST to DONE.
- Each stage state has a wait counter, cleared on entry. If TIMEOUT cycles pass in the state without a done, then:
  - timeout_cnt increments.
  - The frame is aborted: go to DONE with the error flag set.
- DONE lasts one cycle and then returns to IDLE. In that cycle:
  - frame_done=1 and frame_err=error flag.
  - pre_sel<=m_rt and out_sel<=m_en. Both are registered, so the muxes only change at frame boundaries.
  - On an aborted frame, pre_sel and out_sel are instead forced to 0 (raw passthrough).
- A frame_strobe in any state other than IDLE (including DONE) is dropped and overrun_cnt increments. The running frame is unaffected.
- Counters saturate at 2^CNT_W-1. If clr_stats and an increment occur in the same cycle, the clear wins.
- On reset, all outputs and counters go to 0, the state goes to IDLE, and the synchronizers, m_en, m_rt and the error flag go to 0. Reset mid-frame abandons the frame and produces no frame_done.

## Timing
- Strobe at cycle T, full path, with each done arriving on the earliest legal cycle:
  - start[0] at T+1, done[0] at T+2.
  - start[1] at T+3, done[1] at T+4.
  - start[2] at T+5, done[2] at T+6.
  - frame_done at T+7; new pre_sel and out_sel visible from T+8.
- Path without pre-filter: start[1] at T+1 and frame_done at T+5.
- Bypass: frame_done at T+1. busy is high at T+1 only.
- Timeout: a stage entered at cycle S with no done reaches DONE at S+TIMEOUT.
- A switch change reaches the latch after 2 synchronizer cycles and takes effect from the next accepted strobe.
- The next strobe is accepted from the cycle after DONE.

## Structure
- Shared package voice_pkg holds:
  - State encoding constants.
  - Stage index constants STG_PRE=0, STG_SHIFT=1, STG_POST=2.
  - The TIMEOUT default.
- Sub-module sat_counter (parameter W; inputs inc and clr; output cnt) is instantiated twice.
- The synchronizers use the existing dffre register, with en tied to 1.

## Test plan
- Reset: assert reset mid-SHIFT -> all outputs 0, state IDLE, no frame_done; the next strobe runs a clean frame.
- Full path: m_en=1, m_rt=1, stages reply done one cycle after start -> start pulses at T+1, T+3, T+5; frame_done at T+7 with frame_err=0; pre_sel=1 and out_sel=1 at T+8.
- Bypass and early done: change_en=0 -> no start pulses, frame_done at T+1. Separately, done[1] asserted in the start cycle -> ignored, so the state remains SHIFT.
- Overrun: strobe at T, then a second strobe at T+3 and a third in the DONE cycle -> overrun_cnt=2, exactly one frame_done.
- Timeout: TIMEOUT=16, done[2] never asserted -> frame_done with frame_err=1 exactly 16 cycles after POST entry; timeout_cnt=1; pre_sel=0 and out_sel=0.
- Saturation and clear: CNT_W=2, 5 overruns -> overrun_cnt=3; clr_stats in the same cycle as an overrun -> overrun_cnt=0.
